// File: rtl/kanagawa_hal_pkg.sv
// Shared HAL package: parameter range limits for the HAL input blocks and
// the counter-width helper used to size per-channel filter counters.
package kanagawa_hal_pkg;

  localparam int unsigned SYNC_CHANNELS_MIN = 1;
  localparam int unsigned SYNC_CHANNELS_MAX = 64;
  localparam int unsigned SYNC_DEPTH_MIN    = 2;
  localparam int unsigned SYNC_DEPTH_MAX    = 10;
  localparam int unsigned FILTER_CYCLES_MIN = 1;
  localparam int unsigned FILTER_CYCLES_MAX = 65535;

  // Bits needed to hold 0..max_count, i.e. clog2(max_count+1); never below 1.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) <= 64'(max_count)) w++;
    return w;
  endfunction

endpackage

// File: rtl/kanagawa_hal_sync_chain.sv
// Multi-flop synchronizer for WIDTH independent asynchronous bits.
// Ports:
//   clk    - destination clock
//   rst_n  - asynchronous active-low reset, loads RESET_VALUE into every stage
//   d      - asynchronous inputs
//   q      - synchronized outputs (last stage)
module kanagawa_hal_sync_chain #(
  parameter int unsigned       WIDTH       = 1,
  parameter int unsigned       DEPTH       = 2,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = d;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VALUE;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/kanagawa_hal_sync_filter.sv
// Synchronizes CHANNELS asynchronous inputs and deglitches each one: a new
// level is accepted only after FILTER_CYCLES consecutive differing samples.
// Ports:
//   clk        - single clock domain
//   rst_n      - asynchronous active-low reset
//   din        - raw asynchronous inputs
//   glitch_clr - synchronous per-channel clear of the sticky glitch flags
//   dout       - filtered synchronized levels (registered)
//   rise/fall  - one-cycle pulses when dout accepts 0->1 / 1->0
//   glitch     - sticky flag: a transient was seen and rejected
module kanagawa_hal_sync_filter
  import kanagawa_hal_pkg::*;
#(
  parameter int unsigned         CHANNELS      = 8,
  parameter int unsigned         DEPTH         = 2,
  parameter int unsigned         FILTER_CYCLES = 4,
  parameter logic [CHANNELS-1:0] RESET_VALUE   = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] din,
  input  logic [CHANNELS-1:0] glitch_clr,
  output logic [CHANNELS-1:0] dout,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] glitch
);

  localparam int unsigned      CNT_W    = cnt_width(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  if (CHANNELS < SYNC_CHANNELS_MIN || CHANNELS > SYNC_CHANNELS_MAX) begin : g_chk_channels
    $error("kanagawa_hal_sync_filter: CHANNELS=%0d out of range", CHANNELS);
  end
  if (DEPTH < SYNC_DEPTH_MIN || DEPTH > SYNC_DEPTH_MAX) begin : g_chk_depth
    $error("kanagawa_hal_sync_filter: DEPTH=%0d out of range", DEPTH);
  end
  if (FILTER_CYCLES < FILTER_CYCLES_MIN || FILTER_CYCLES > FILTER_CYCLES_MAX) begin : g_chk_filter
    $error("kanagawa_hal_sync_filter: FILTER_CYCLES=%0d out of range", FILTER_CYCLES);
  end

  logic [CHANNELS-1:0] s;

  kanagawa_hal_sync_chain #(
    .WIDTH       (CHANNELS),
    .DEPTH       (DEPTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (din),
    .q     (s)
  );

  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];
  logic [CHANNELS-1:0] dout_q,   dout_d;
  logic [CHANNELS-1:0] rise_q,   rise_d;
  logic [CHANNELS-1:0] fall_q,   fall_d;
  logic [CHANNELS-1:0] glitch_q, glitch_d;

  always_comb begin
    dout_d   = dout_q;
    rise_d   = '0;
    fall_d   = '0;
    // Clear first, then OR in new glitches so a same-cycle set wins.
    glitch_d = glitch_q & ~glitch_clr;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      cnt_d[ch] = cnt_q[ch];
      if (s[ch] == dout_q[ch]) begin
        // Sample fell back before qualifying: any partial count was a glitch.
        cnt_d[ch] = '0;
        if (cnt_q[ch] != '0) glitch_d[ch] = 1'b1;
      end else if (cnt_q[ch] == CNT_LAST) begin
        dout_d[ch] = s[ch];
        cnt_d[ch]  = '0;
        rise_d[ch] = s[ch];
        fall_d[ch] = ~s[ch];
      end else begin
        cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
        cnt_q[ch] <= '0;
      end
      dout_q   <= RESET_VALUE;
      rise_q   <= '0;
      fall_q   <= '0;
      glitch_q <= '0;
    end else begin
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
        cnt_q[ch] <= cnt_d[ch];
      end
      dout_q   <= dout_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign dout   = dout_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign glitch = glitch_q;

endmodule
